// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, CPOL/CPHA, bit order, runtime
// baud divider and one-hot active-low slave selects. done mirrors the legacy SPIF flag.
module spi_master_param #(
    parameter  int DATA_W = 8,
    parameter  int NUM_SS = 4,
    parameter  int DIV_W  = 8,
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int              EC_W      = $clog2(2 * DATA_W + 1);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsbfe_q, lsbfe_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick, leading, last_edge;

    function automatic logic out_bit(input logic [DATA_W-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] sr, input logic lsb);
        return lsb ? {1'b0, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], 1'b0};
    endfunction

    // LSB-first fills from the top so the first received bit lands in bit 0.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr, input logic lsb,
                                                   input logic b);
        return lsb ? {b, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], b};
    endfunction

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    // The timer reloads with clk_div and expires at zero, so H = 2^DIV_W never overflows it.
    assign tick      = (timer_q == '0);
    assign leading   = ~edge_cnt_q[0];
    assign last_edge = (edge_cnt_q == LAST_EDGE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)             state_d = SETUP;
            SETUP:   if (tick)              state_d = XFER;
            XFER:    if (tick && last_edge) state_d = HOLD;
            HOLD:    if (tick)              state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d    = timer_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsbfe_d    = lsbfe_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        ss_n_d     = ss_n_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                sck_d  = cpol;
                ss_n_d = '1;
                busy_d = 1'b0;
                if (start) begin
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsbfe_d    = lsbfe;
                    div_d      = clk_div;
                    timer_d    = clk_div;
                    edge_cnt_d = '0;
                    rx_sr_d    = '0;
                    busy_d     = 1'b1;
                    ss_n_d     = ss_decode(ss_sel);
                    // CPHA=0 must present the first bit before the first leading edge.
                    if (!cpha) begin
                        mosi_d  = out_bit(tx_data, lsbfe);
                        tx_sr_d = shift_out(tx_data, lsbfe);
                    end else begin
                        tx_sr_d = tx_data;
                    end
                end
            end
            SETUP, XFER: begin
                if (tick) begin
                    timer_d    = div_q;
                    sck_d      = ~sck_q;
                    edge_cnt_d = edge_cnt_q + EC_W'(1);
                    if (leading != cpha_q) rx_sr_d = shift_in(rx_sr_q, lsbfe_q, miso);
                    if (cpha_q ? leading : (!leading && !last_edge)) begin
                        mosi_d  = out_bit(tx_sr_q, lsbfe_q);
                        tx_sr_d = shift_out(tx_sr_q, lsbfe_q);
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            HOLD: begin
                if (tick) begin
                    ss_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q    <= '0;
            div_q      <= '0;
            edge_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbfe_q    <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            ss_n_q     <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsbfe_q    <= lsbfe_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            ss_n_q     <= ss_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboarded bench for spi_master_param: a driver queues expected transfers, a
// negedge monitor acts as SPI slave, measures timing and checks each done pulse.
module tb_spi_master_param;

    localparam int DW  = 8;
    localparam int NSS = 6;
    localparam int DVW = 4;
    localparam int SSW = 3;

    typedef struct {
        logic [DW-1:0]  rx_exp;
        logic [DW-1:0]  tx;
        logic [DW-1:0]  slv;
        logic           cpol, cpha, lsbfe, loop;
        logic [NSS-1:0] ss_exp;
        int             h;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic start, cpol, cpha, lsbfe;
    logic [DW-1:0]  tx_data;
    logic [SSW-1:0] ss_sel;
    logic [DVW-1:0] clk_div;
    logic miso, sck, mosi, busy, done;
    logic [NSS-1:0] ss_n;
    logic [DW-1:0]  rx_data;

    logic lp_en = 1'b1;
    logic slave_bit = 1'b0;
    assign miso = lp_en ? mosi : slave_bit;

    int checks = 0;
    int failures = 0;
    item_t sbq[$];

    spi_master_param #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DVW)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .clk_div(clk_div), .miso(miso),
        .sck(sck), .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input bit cp, ph, lf, input logic [DVW-1:0] dv,
                                 input logic [DW-1:0] tx, input logic [SSW-1:0] sel,
                                 input bit lp, input logic [DW-1:0] sw);
        item_t it;
        it.tx = tx; it.slv = sw; it.loop = lp;
        it.rx_exp = lp ? tx : sw;
        it.cpol = cp; it.cpha = ph; it.lsbfe = lf;
        it.h = int'(dv) + 1;
        it.ss_exp = '1;
        if (int'(sel) < NSS) it.ss_exp[sel] = 1'b0;
        return it;
    endfunction

    task automatic scramble();
        tx_data = DW'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        lsbfe = 1'($urandom); clk_div = DVW'($urandom); ss_sel = SSW'($urandom);
        start = 1'($urandom);
    endtask

    task automatic wait_idle(input bit scr);
        for (int i = 0; i < 5000 && busy; i++) begin
            if (scr) scramble();
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (busy) chk("timeout_busy", 1, 0);
    endtask

    // Called at posedge+1 with the DUT idle (or in its done cycle).
    task automatic xfer(input bit cp, ph, lf, input logic [DVW-1:0] dv, input logic [DW-1:0] tx,
                        input logic [SSW-1:0] sel, input bit lp, input logic [DW-1:0] sw,
                        input bit scr);
        sbq.push_back(mk(cp, ph, lf, dv, tx, sel, lp, sw));
        cpol = cp; cpha = ph; lsbfe = lf; clk_div = dv; tx_data = tx; ss_sel = sel;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(scr);
    endtask

    // Monitor / slave model
    item_t cur;
    bit act = 0, pbusy = 0, psck = 0;
    int n, tg, ft, lt, bk, ssbad, pos;
    logic [DW-1:0] srx;

    always @(negedge clk) begin
        if (!rst) begin
            act = 0; pbusy = 0; psck = 0;
        end else begin
            if (busy && !pbusy) begin
                chk("busy_without_request", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    cur = sbq[0]; act = 1;
                    n = 0; tg = 0; ft = 0; lt = 0; bk = 0; ssbad = 0; srx = '0;
                    lp_en = cur.loop;
                    slave_bit = cur.slv[cur.lsbfe ? 0 : DW-1];
                    chk("sck_at_start", sck, cur.cpol);
                end
            end
            if (act && busy) begin
                n++;
                if (pbusy && sck !== psck) begin
                    tg++;
                    if (tg == 1) ft = n;
                    lt = n;
                    // leading edges are odd toggles; slave samples where the master does
                    if (((tg % 2) == 1) != cur.cpha) begin
                        pos = cur.lsbfe ? bk : DW-1-bk;
                        srx[pos] = mosi;
                        bk++;
                        if (bk < DW) slave_bit = cur.slv[cur.lsbfe ? bk : DW-1-bk];
                    end
                end
                if (ss_n !== cur.ss_exp) ssbad++;
            end
            if (done) begin
                if (!act) chk("done_without_transfer", 1, 0);
                else begin
                    void'(sbq.pop_front());
                    chk("rx_data", rx_data, cur.rx_exp);
                    chk("slave_saw_tx", srx, cur.tx);
                    chk("busy_cycles", n, (2*DW+1)*cur.h);
                    chk("sck_toggles", tg, 2*DW);
                    chk("first_edge_cycle", ft, cur.h + 1);
                    chk("last_edge_cycle", lt, 1 + 2*DW*cur.h);
                    chk("ss_n_during_xfer_bad_cycles", ssbad, 0);
                    chk("ss_n_at_done", ss_n, {NSS{1'b1}});
                    chk("busy_at_done", busy, 0);
                    chk("sck_at_done", sck, cur.cpol);
                    act = 0;
                end
            end
            pbusy = busy; psck = sck;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        tx_data = '0; ss_sel = '0; clk_div = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ss_n", ss_n, {NSS{1'b1}});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Mode 0, MSB first, H=2, loopback
        xfer(0, 0, 0, 4'd1, 8'hA5, 3'd0, 1, 8'h00, 0);

        // Mode 3, LSB first, miso tied high, sck idles high
        cpol = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        chk("sck_idle_high_before", sck, 1);
        xfer(1, 1, 1, 4'd2, 8'h01, 3'd1, 0, 8'hFF, 0);
        @(posedge clk); #1;
        chk("sck_idle_high_after", sck, 1);

        // Mode 1, H=1, start held: two back-to-back transfers on slave 2
        sbq.push_back(mk(0, 1, 0, 4'd0, 8'h3C, 3'd2, 1, 8'h00));
        sbq.push_back(mk(0, 1, 0, 4'd0, 8'h3C, 3'd2, 1, 8'h00));
        cpol = 1'b0; cpha = 1'b1; lsbfe = 1'b0; clk_div = 4'd0; tx_data = 8'h3C; ss_sel = 3'd2;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200 && !done; i++) begin @(posedge clk); #1; end
        chk("b2b_first_done", done, 1);
        chk("b2b_gap_ss_high", ss_n[2], 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_ss_low", ss_n[2], 0);
        wait_idle(0);

        // Reset at cycle 10 of a transfer
        @(posedge clk); #1;
        sbq.push_back(mk(1, 0, 0, 4'd3, 8'hC3, 3'd1, 1, 8'h00));
        cpol = 1'b1; cpha = 1'b0; clk_div = 4'd3; tx_data = 8'hC3; ss_sel = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_sck", sck, 0);
        chk("midrst_ss_n", ss_n, {NSS{1'b1}});
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        sbq.delete();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        xfer(0, 0, 1, 4'd1, 8'h5A, 3'd3, 0, 8'h81, 0);

        // Out-of-range slave selects
        xfer(0, 0, 0, 4'd0, 8'h96, 3'd7, 1, 8'h00, 0);
        xfer(1, 0, 0, 4'd1, 8'h69, 3'd6, 0, 8'h42, 0);

        // Maximum divider, H = 2^DIV_W
        xfer(1, 1, 0, 4'hF, 8'hE7, 3'd5, 0, 8'h5A, 0);

        // Inputs perturbed while busy must not disturb the running transfer
        xfer(0, 1, 1, 4'd1, 8'hB4, 3'd4, 1, 8'h00, 1);

        for (int k = 0; k < 25; k++)
            xfer(1'($urandom), 1'($urandom), 1'($urandom), DVW'($urandom_range(0, 3)),
                 DW'($urandom), SSW'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
